// File: rtl/clk_ratio_meter.sv
// clk_ratio_meter
//   Measures the spacing, in clk cycles, between consecutive edges (rising or
//   falling) of a slow square wave, e.g. the output of the programmable clock
//   divider. This recovers the divide ratio. The block reports every
//   half-period, declares lock after LOCK_COUNT identical results in a row, and
//   flags loss of signal when no edge arrives within MAX cycles.
//
// Ports
//   clk          measurement clock, rising edge
//   rst          synchronous, active-high reset
//   sig_in       signal under test, asynchronous to clk
//   meas_en      measurement enable; low forces IDLE
//   half_period  last valid measurement (1..MAX)
//   meas_valid   one-cycle pulse when half_period updates
//   locked       LOCK_COUNT consecutive equal measurements seen
//   overflow     no edge within MAX cycles; cleared by the next measurement
//   state_dbg    current FSM state (0 IDLE, 1 ARM, 2 MEASURE)
module clk_ratio_meter #(
  parameter int CNT_W       = 8,
  parameter int SYNC_STAGES = 2,
  parameter int LOCK_COUNT  = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             sig_in,
  input  logic             meas_en,
  output logic [CNT_W-1:0] half_period,
  output logic             meas_valid,
  output logic             locked,
  output logic             overflow,
  output logic [1:0]       state_dbg
);

  localparam int MW = $clog2(LOCK_COUNT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [MW-1:0]    M_ONE   = MW'(1);
  localparam logic [MW-1:0]    M_LOCK  = MW'(LOCK_COUNT);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ARM     = 2'd1,
    MEASURE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic              prev_q;
  logic              sig_edge;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [MW-1:0]     match_q, match_d;
  logic [CNT_W-1:0]  hp_d;
  logic              mv_d, lock_d, ovf_d;

  // Synchronizer and edge detector run in every state, so a re-enable never
  // sees a stale edge. sync_q[0] is the newest sample.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], sig_in};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign sig_edge = sync_q[SYNC_STAGES-1] ^ prev_q;

  // match_q == 0 means no measurement has been taken since the last (re)arm,
  // so the first result after ARM never compares against a stale half_period.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    match_d = match_q;
    hp_d    = half_period;
    mv_d    = 1'b0;
    lock_d  = locked;
    ovf_d   = overflow;
    if (!meas_en) begin
      state_d = IDLE;
      cnt_d   = '0;
      match_d = '0;
      lock_d  = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          cnt_d   = '0;
          state_d = ARM;
        end
        ARM: begin
          if (sig_edge) begin
            cnt_d   = CNT_ONE;
            state_d = MEASURE;
          end
        end
        MEASURE: begin
          // An edge in the same cycle as cnt_q == MAX is a valid measurement.
          if (sig_edge) begin
            hp_d  = cnt_q;
            mv_d  = 1'b1;
            ovf_d = 1'b0;
            cnt_d = CNT_ONE;
            if (match_q != '0 && cnt_q == half_period)
              match_d = (match_q == M_LOCK) ? M_LOCK : match_q + M_ONE;
            else
              match_d = M_ONE;
            lock_d = (match_d == M_LOCK);
          end else if (cnt_q == CNT_MAX) begin
            ovf_d   = 1'b1;
            lock_d  = 1'b0;
            match_d = '0;
            cnt_d   = '0;
            state_d = ARM;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
          match_d = '0;
          lock_d  = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      match_q     <= '0;
      half_period <= '0;
      meas_valid  <= 1'b0;
      locked      <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      match_q     <= match_d;
      half_period <= hp_d;
      meas_valid  <= mv_d;
      locked      <= lock_d;
      overflow    <= ovf_d;
    end
  end

  assign state_dbg = state_q;

endmodule

// File: tb/tb_clk_ratio_meter.sv
module tb_clk_ratio_meter;
  localparam int CNT_W = 8;
  localparam int SYNC  = 2;
  localparam int LOCKN = 4;
  localparam int MAXV  = 255;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic sig_in = 1'b0;
  logic meas_en = 1'b1;
  logic [CNT_W-1:0] half_period;
  logic meas_valid, locked, overflow;
  logic [1:0] state_dbg;

  always #5 clk = ~clk;

  clk_ratio_meter #(.CNT_W(CNT_W), .SYNC_STAGES(SYNC), .LOCK_COUNT(LOCKN)) dut (
    .clk(clk), .rst(rst), .sig_in(sig_in), .meas_en(meas_en),
    .half_period(half_period), .meas_valid(meas_valid), .locked(locked),
    .overflow(overflow), .state_dbg(state_dbg)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d expected=%0d at t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // sig_in is kept as a delay line of per-edge samples; the FSM is modelled
  // with time stamps: a measurement is the cycle distance between counted edges.
  logic hist[0:SYNC];
  int   mode = 0;          // 0 idle, 1 armed, 2 measuring
  int   last_edge = 0;
  int   cyc = 0;
  int   runs = 0;          // consecutive equal measurements since arm
  int   elapsed;
  logic e;
  logic [CNT_W-1:0] m_hp = '0;
  logic m_mv = 1'b0, m_lock = 1'b0, m_ovf = 1'b0;
  bit   live = 1'b0;

  always @(posedge clk) begin
    cyc++;
    if (rst) begin
      for (int i = 0; i <= SYNC; i++) hist[i] = 1'b0;
      mode = 0; runs = 0; m_hp = '0; m_mv = 1'b0; m_lock = 1'b0; m_ovf = 1'b0;
      live = 1'b1;
    end else begin
      e = hist[SYNC-1] ^ hist[SYNC];
      for (int i = SYNC; i > 0; i--) hist[i] = hist[i-1];
      hist[0] = sig_in;
      m_mv = 1'b0;
      if (!meas_en) begin
        mode = 0; m_lock = 1'b0; runs = 0;
      end else if (mode == 0) begin
        mode = 1;
      end else if (mode == 1) begin
        if (e) begin mode = 2; last_edge = cyc; end
      end else begin
        elapsed = cyc - last_edge;
        if (e) begin
          if (runs > 0 && elapsed == int'(m_hp)) runs = (runs < LOCKN) ? runs + 1 : LOCKN;
          else runs = 1;
          m_hp = CNT_W'(elapsed);
          m_mv = 1'b1;
          m_ovf = 1'b0;
          m_lock = (runs == LOCKN);
          last_edge = cyc;
        end else if (elapsed == MAXV) begin
          m_ovf = 1'b1; m_lock = 1'b0; runs = 0; mode = 1;
        end
      end
    end
  end

  // ---------------- scoreboard / monitor ----------------
  logic [CNT_W-1:0] exp_q[$];
  logic             exp_lk_q[$];
  logic [CNT_W-1:0] obs_hp_q[$];
  logic             obs_lk_q[$];
  logic             obs_ov_q[$];
  int ncyc = 0;
  int last_mv_cyc = 0;
  int ovf_rise_cyc = 0;
  logic ovf_prev = 1'b0;

  always @(negedge clk) begin
    ncyc++;
    if (live) begin
      checks++;
      if ({half_period, meas_valid, locked, overflow} !== {m_hp, m_mv, m_lock, m_ovf}) begin
        failures++;
        $display("FAIL cycle_model t=%0t actual hp=%0d mv=%b lk=%b ov=%b expected hp=%0d mv=%b lk=%b ov=%b",
                 $time, half_period, meas_valid, locked, overflow, m_hp, m_mv, m_lock, m_ovf);
      end
    end
    if (meas_valid === 1'b1) begin
      obs_hp_q.push_back(half_period);
      obs_lk_q.push_back(locked);
      obs_ov_q.push_back(overflow);
      last_mv_cyc = ncyc;
    end
    if (overflow === 1'b1 && !ovf_prev) ovf_rise_cyc = ncyc;
    ovf_prev = (overflow === 1'b1);
  end

  // ---------------- driver tasks ----------------
  task automatic settle(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic toggle_every(input int p, input int n);
    for (int i = 0; i < n; i++) begin
      repeat (p) @(negedge clk);
      sig_in = ~sig_in;
    end
  endtask

  task automatic clear_obs();
    obs_hp_q.delete(); obs_lk_q.delete(); obs_ov_q.delete();
    exp_q.delete(); exp_lk_q.delete();
  endtask

  task automatic rearm();
    @(negedge clk); meas_en = 1'b0;
    @(negedge clk); meas_en = 1'b1;
    #1;
    clear_obs();
  endtask

  // n fresh measurements of value hp, lock expected from the LOCKN-th onward
  task automatic expect_run(input int hp, input int n);
    for (int k = 1; k <= n; k++) begin
      exp_q.push_back(CNT_W'(hp));
      exp_lk_q.push_back(k >= LOCKN);
    end
  endtask

  task automatic check_obs(input string name);
    check({name, "_count"}, obs_hp_q.size(), exp_q.size());
    while (exp_q.size() > 0 && obs_hp_q.size() > 0) begin
      check({name, "_hp"}, obs_hp_q.pop_front(), exp_q.pop_front());
      check({name, "_lock"}, obs_lk_q.pop_front(), exp_lk_q.pop_front());
      check({name, "_ovf"}, obs_ov_q.pop_front(), 0);
    end
    clear_obs();
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int p;
    int r;
    // reset with sig_in wiggling
    repeat (3) begin
      @(negedge clk);
      sig_in = 1'($urandom_range(0, 1));
    end
    @(negedge clk); sig_in = 1'b0;
    #1;
    check("rst_hp", half_period, 0);
    check("rst_mv", meas_valid, 0);
    check("rst_lock", locked, 0);
    check("rst_ovf", overflow, 0);
    rst = 1'b0;
    settle(1);
    check("rst_to_arm", state_dbg, 1);
    clear_obs();

    // steady 5, then ratio change to 7
    toggle_every(5, 10);
    toggle_every(7, 10);
    settle(20);
    expect_run(5, 9);
    expect_run(7, 10);
    check_obs("ratio_5_7");

    // fastest toggle
    rearm();
    toggle_every(1, 8);
    settle(SYNC + 4);
    expect_run(1, 7);
    check_obs("period_1");

    // MAX period, then loss of signal
    rearm();
    toggle_every(255, 3);
    settle(300);
    expect_run(255, 2);
    check_obs("period_255");
    check("ovf_set", overflow, 1);
    check("ovf_lock", locked, 0);
    check("ovf_hp_hold", half_period, 255);
    check("ovf_delay", ovf_rise_cyc - last_mv_cyc, 255);

    // resume: first edge re-arms, lock builds again
    toggle_every(10, 10);
    settle(4);
    expect_run(10, 9);
    check_obs("resume_10");
    check("resume_ovf_clear", overflow, 0);
    check("resume_locked", locked, 1);

    // drop enable mid-period while locked
    meas_en = 1'b0;
    settle(1);
    check("disable_lock", locked, 0);
    check("disable_hp_hold", half_period, 10);
    toggle_every(10, 3);
    settle(SYNC + 3);
    check_obs("disabled");
    meas_en = 1'b1;
    toggle_every(10, 3);
    settle(SYNC + 3);
    expect_run(10, 2);
    check_obs("reenable");

    // reset while measuring
    toggle_every(6, 2);
    settle(2);
    rst = 1'b1;
    settle(1);
    check("rst_mid_hp", half_period, 0);
    check("rst_mid_lock", locked, 0);
    check("rst_mid_ovf", overflow, 0);
    check("rst_mid_mv", meas_valid, 0);
    rst = 1'b0;

    // randomized traffic, checked by the cycle model
    p = 5;
    for (int it = 0; it < 150; it++) begin
      r = $urandom_range(0, 19);
      if (r == 0) begin
        meas_en = 1'b0;
        toggle_every($urandom_range(1, 20), $urandom_range(1, 4));
        meas_en = 1'b1;
      end else if (r == 1) begin
        settle($urandom_range(250, 270));
      end else if (r == 2) begin
        @(negedge clk); rst = 1'b1;
        @(negedge clk); rst = 1'b0;
      end else if (r == 3) begin
        toggle_every($urandom_range(253, 255), 2);
      end else begin
        if ($urandom_range(0, 3) == 0) p = $urandom_range(1, 40);
        toggle_every(p, $urandom_range(2, 8));
      end
    end
    settle(10);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
